// File: rtl/noc_local_ni_pkg.sv
// Shared NoC constants and flit payload types for the router and the local network interface.
package noc_local_ni_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned MESH_SIDE  = 4;
  localparam int unsigned COORD_W    = $clog2(MESH_SIDE);

  // Flit as carried on router ports: payload, destination and the negative-direction hints.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [COORD_W-1:0]    dest_x;
    logic [COORD_W-1:0]    dest_y;
    logic                  s_delta_x;
    logic                  s_delta_y;
  } flit_t;

  // Entry kept in the eject buffer; the direction hints are meaningless once ejected.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [COORD_W-1:0]    dest_x;
    logic [COORD_W-1:0]    dest_y;
  } rx_entry_t;

  localparam int unsigned FLIT_W     = $bits(flit_t);
  localparam int unsigned RX_ENTRY_W = $bits(rx_entry_t);

  // Build an outgoing flit; a set s_delta bit means the destination lies at a lower coordinate.
  function automatic flit_t make_flit(input logic [DATA_WIDTH-1:0] data,
                                      input logic [COORD_W-1:0]    dest_x,
                                      input logic [COORD_W-1:0]    dest_y,
                                      input int unsigned           own_x,
                                      input int unsigned           own_y);
    flit_t f;
    f.data      = data;
    f.dest_x    = dest_x;
    f.dest_y    = dest_y;
    f.s_delta_x = (dest_x < COORD_W'(own_x));
    f.s_delta_y = (dest_y < COORD_W'(own_y));
    return f;
  endfunction

endpackage

// File: rtl/noc_local_ni_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers; used for inject and eject buffering.
module ni_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags: equal pointers mean empty, differing only in the MSB means full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for pointers and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // State registers; storage is cleared so nothing stale is visible after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: core-side valid/ready inject and eject paths bridging to the router LOCAL port.
module noc_local_ni
  import noc_local_ni_pkg::*;
#(
  parameter int unsigned X_COORD  = 0,
  parameter int unsigned Y_COORD  = 0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // core inject side
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [COORD_W-1:0]    tx_dest_x,
  input  logic [COORD_W-1:0]    tx_dest_y,
  // core eject side
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_overflow,
  output logic                  rx_misroute,
  output logic [15:0]           tx_cnt,
  output logic [15:0]           rx_cnt,
  // router LOCAL input
  output logic                  noc_tx_valid,
  input  logic                  noc_tx_ready,
  output logic [DATA_WIDTH-1:0] noc_tx_data,
  output logic [COORD_W-1:0]    noc_tx_dest_x,
  output logic [COORD_W-1:0]    noc_tx_dest_y,
  output logic                  noc_tx_s_delta_x,
  output logic                  noc_tx_s_delta_y,
  // router LOCAL output
  input  logic                  noc_rx_valid,
  output logic                  noc_rx_ready,
  input  logic [DATA_WIDTH-1:0] noc_rx_data,
  input  logic [COORD_W-1:0]    noc_rx_dest_x,
  input  logic [COORD_W-1:0]    noc_rx_dest_y
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  // ---------------- inject path ----------------
  flit_t            tx_wflit;
  logic [FLIT_W-1:0] tx_head_raw;
  flit_t            tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic [TX_CW-1:0] unused_tx_count;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_xfer;
  logic             stage_load;

  logic             out_valid_q, out_valid_d;
  flit_t            out_flit_q, out_flit_d;
  logic [15:0]      tx_cnt_q, tx_cnt_d;

  assign tx_ready   = !tx_full;
  assign tx_push    = tx_valid && tx_ready;
  assign tx_wflit   = make_flit(tx_data, tx_dest_x, tx_dest_y, X_COORD, Y_COORD);
  assign tx_head    = flit_t'(tx_head_raw);
  assign tx_xfer    = out_valid_q && noc_tx_ready;
  assign stage_load = !out_valid_q || tx_xfer;
  assign tx_pop     = stage_load && !tx_empty;

  ni_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (tx_wflit),
    .rdata (tx_head_raw),
    .full  (tx_full),
    .empty (tx_empty),
    .count (unused_tx_count)
  );

  // Output stage: refill from the FIFO head when empty or draining; hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    tx_cnt_d    = tx_cnt_q + 16'(tx_xfer);
    if (stage_load) begin
      out_valid_d = !tx_empty;
      if (!tx_empty) begin
        out_flit_d = tx_head;
      end
    end
  end

  // Inject registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      tx_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  assign noc_tx_valid     = out_valid_q;
  assign noc_tx_data      = out_flit_q.data;
  assign noc_tx_dest_x    = out_flit_q.dest_x;
  assign noc_tx_dest_y    = out_flit_q.dest_y;
  assign noc_tx_s_delta_x = out_flit_q.s_delta_x;
  assign noc_tx_s_delta_y = out_flit_q.s_delta_y;
  assign tx_cnt           = tx_cnt_q;

  // ---------------- eject path ----------------
  rx_entry_t            rx_wentry;
  logic [RX_ENTRY_W-1:0] rx_head_raw;
  rx_entry_t            rx_head;
  logic                 rx_full;
  logic                 rx_empty;
  logic [RX_CW-1:0]     rx_count;
  logic [RX_CW-1:0]     rx_count_next;
  logic                 rx_pop;
  logic                 rx_push_ok;
  logic                 rx_drop;
  logic                 rx_wrong_tile;

  logic                 rx_ready_q, rx_ready_d;
  logic                 overflow_q, overflow_d;
  logic                 misroute_q, misroute_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;

  assign rx_wentry     = '{data: noc_rx_data, dest_x: noc_rx_dest_x, dest_y: noc_rx_dest_y};
  assign rx_head       = rx_entry_t'(rx_head_raw);
  assign rx_pop        = !rx_empty && rx_ready;
  // A push into a full buffer still lands if the core frees the head on the same edge.
  assign rx_push_ok    = noc_rx_valid && (!rx_full || rx_pop);
  assign rx_drop       = noc_rx_valid && rx_full && !rx_pop;
  assign rx_wrong_tile = (noc_rx_dest_x != COORD_W'(X_COORD)) || (noc_rx_dest_y != COORD_W'(Y_COORD));
  assign rx_count_next = rx_count + RX_CW'(rx_push_ok) - RX_CW'(rx_pop);

  ni_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_ok),
    .pop   (rx_pop),
    .wdata (rx_wentry),
    .rdata (rx_head_raw),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Eject control: ready leaves room for the flit already in flight when the router sees it drop.
  always_comb begin
    rx_ready_d = (rx_count_next <= RX_CW'(RX_DEPTH - 2));
    overflow_d = overflow_q || rx_drop;
    misroute_d = misroute_q || (rx_push_ok && rx_wrong_tile);
    rx_cnt_d   = rx_cnt_q + 16'(rx_push_ok);
  end

  // Eject registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      misroute_q <= 1'b0;
      rx_cnt_q   <= '0;
    end else begin
      rx_ready_q <= rx_ready_d;
      overflow_q <= overflow_d;
      misroute_q <= misroute_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign noc_rx_ready = rx_ready_q;
  assign rx_valid     = !rx_empty;
  assign rx_data      = rx_head.data;
  assign rx_overflow  = overflow_q;
  assign rx_misroute  = misroute_q;
  assign rx_cnt       = rx_cnt_q;

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni at tile (1,1) with 4-entry inject and eject buffers.
module tb_noc_local_ni;
  import noc_local_ni_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [COORD_W-1:0]    tx_dest_x;
  logic [COORD_W-1:0]    tx_dest_y;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_overflow;
  logic                  rx_misroute;
  logic [15:0]           tx_cnt;
  logic [15:0]           rx_cnt;
  logic                  noc_tx_valid;
  logic                  noc_tx_ready;
  logic [DATA_WIDTH-1:0] noc_tx_data;
  logic [COORD_W-1:0]    noc_tx_dest_x;
  logic [COORD_W-1:0]    noc_tx_dest_y;
  logic                  noc_tx_s_delta_x;
  logic                  noc_tx_s_delta_y;
  logic                  noc_rx_valid;
  logic                  noc_rx_ready;
  logic [DATA_WIDTH-1:0] noc_rx_data;
  logic [COORD_W-1:0]    noc_rx_dest_x;
  logic [COORD_W-1:0]    noc_rx_dest_y;

  int tests_run;
  int tests_failed;

  noc_local_ni #(
    .X_COORD  (1),
    .Y_COORD  (1),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .tx_dest_x        (tx_dest_x),
    .tx_dest_y        (tx_dest_y),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .rx_data          (rx_data),
    .rx_overflow      (rx_overflow),
    .rx_misroute      (rx_misroute),
    .tx_cnt           (tx_cnt),
    .rx_cnt           (rx_cnt),
    .noc_tx_valid     (noc_tx_valid),
    .noc_tx_ready     (noc_tx_ready),
    .noc_tx_data      (noc_tx_data),
    .noc_tx_dest_x    (noc_tx_dest_x),
    .noc_tx_dest_y    (noc_tx_dest_y),
    .noc_tx_s_delta_x (noc_tx_s_delta_x),
    .noc_tx_s_delta_y (noc_tx_s_delta_y),
    .noc_rx_valid     (noc_rx_valid),
    .noc_rx_ready     (noc_rx_ready),
    .noc_rx_data      (noc_rx_data),
    .noc_rx_dest_x    (noc_rx_dest_x),
    .noc_rx_dest_y    (noc_rx_dest_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one active edge; outputs are sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    tests_run++; if (noc_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_noc_tx_valid: got %0h expected 0", noc_tx_valid); end
    tests_run++; if (noc_tx_data !== 16'h0) begin tests_failed++; $display("FAIL rst_noc_tx_data: got %0h expected 0", noc_tx_data); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_tx_ready: got %0h expected 1", tx_ready); end
    tests_run++; if (noc_rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_noc_rx_ready: got %0h expected 1", noc_rx_ready); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rx_valid: got %0h expected 0", rx_valid); end
    tests_run++; if (rx_data !== 16'h0) begin tests_failed++; $display("FAIL rst_rx_data: got %0h expected 0", rx_data); end
    tests_run++; if ({rx_overflow, rx_misroute} !== 2'b00) begin tests_failed++; $display("FAIL rst_sticky: got %0b expected 00", {rx_overflow, rx_misroute}); end
    tests_run++; if ({tx_cnt, rx_cnt} !== 32'h0) begin tests_failed++; $display("FAIL rst_counters: got %0h expected 0", {tx_cnt, rx_cnt}); end
    rst = 1'b1;
  endtask

  // Single flit: two-edge latency, s_delta computed against tile (1,1).
  task automatic test_single_inject();
    noc_tx_ready = 1'b1;
    tx_valid = 1'b1; tx_data = 16'h00A5; tx_dest_x = 2'd3; tx_dest_y = 2'd0;
    tick();
    tx_valid = 1'b0;
    tests_run++; if (noc_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid: got %0h expected 0", noc_tx_valid); end
    tick();
    tests_run++; if (noc_tx_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0h expected 1", noc_tx_valid); end
    tests_run++; if (noc_tx_data !== 16'h00A5) begin tests_failed++; $display("FAIL single_data: got %0h expected a5", noc_tx_data); end
    tests_run++; if ({noc_tx_dest_x, noc_tx_dest_y} !== 4'b11_00) begin tests_failed++; $display("FAIL single_dest: got %0b expected 1100", {noc_tx_dest_x, noc_tx_dest_y}); end
    tests_run++; if ({noc_tx_s_delta_x, noc_tx_s_delta_y} !== 2'b01) begin tests_failed++; $display("FAIL single_s_delta: got %0b expected 01", {noc_tx_s_delta_x, noc_tx_s_delta_y}); end
    tick();
    tests_run++; if (noc_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL single_valid_clear: got %0h expected 0", noc_tx_valid); end
    tests_run++; if (tx_cnt !== 16'd1) begin tests_failed++; $display("FAIL single_tx_cnt: got %0d expected 1", tx_cnt); end
  endtask

  // Router stalled: stage plus 4 FIFO entries fill, then drain one per cycle in order.
  task automatic test_tx_backpressure();
    noc_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_tx_ready_open%0d: got %0h expected 1", i, tx_ready); end
      tx_valid = 1'b1; tx_data = 16'h0100 + 16'(i); tx_dest_x = 2'd0; tx_dest_y = 2'd2;
      tick();
    end
    tx_valid = 1'b0;
    tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_tx_ready_full: got %0h expected 0", tx_ready); end
    tests_run++; if ({noc_tx_s_delta_x, noc_tx_s_delta_y} !== 2'b10) begin tests_failed++; $display("FAIL bp_s_delta: got %0b expected 10", {noc_tx_s_delta_x, noc_tx_s_delta_y}); end
    tick();
    tick();
    tests_run++; if ({noc_tx_valid, noc_tx_data} !== {1'b1, 16'h0100}) begin tests_failed++; $display("FAIL bp_stable: got %0h expected 10100", {noc_tx_valid, noc_tx_data}); end
    noc_tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if ({noc_tx_valid, noc_tx_data} !== {1'b1, 16'h0100 + 16'(i)}) begin tests_failed++; $display("FAIL bp_order%0d: got %0h expected %0h", i, {noc_tx_valid, noc_tx_data}, {1'b1, 16'h0100 + 16'(i)}); end
      tick();
    end
    tests_run++; if (noc_tx_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %0h expected 0", noc_tx_valid); end
    tests_run++; if (tx_cnt !== 16'd6) begin tests_failed++; $display("FAIL bp_tx_cnt: got %0d expected 6", tx_cnt); end
  endtask

  // Router model reacts to ready one cycle late; 6 flits offered, core not consuming.
  task automatic test_rx_backpressure();
    logic rdy_late;
    int   sent;
    int   fall_cyc;
    rdy_late = 1'b1; sent = 0; fall_cyc = -1;
    rx_ready = 1'b0;
    noc_rx_dest_x = 2'd1; noc_rx_dest_y = 2'd1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      noc_rx_valid = (sent < 6) && rdy_late;
      noc_rx_data  = 16'h0200 + 16'(sent);
      if (noc_rx_valid) sent++;
      if (noc_rx_ready == 1'b0 && fall_cyc < 0) fall_cyc = cyc;
      rdy_late = noc_rx_ready;
      tick();
    end
    noc_rx_valid = 1'b0;
    tests_run++; if (fall_cyc != 3) begin tests_failed++; $display("FAIL rxbp_ready_fall: got %0d expected 3", fall_cyc); end
    tests_run++; if (sent != 4) begin tests_failed++; $display("FAIL rxbp_sent: got %0d expected 4", sent); end
    tests_run++; if (rx_cnt !== 16'd4) begin tests_failed++; $display("FAIL rxbp_rx_cnt: got %0d expected 4", rx_cnt); end
    tests_run++; if (noc_rx_ready !== 1'b0) begin tests_failed++; $display("FAIL rxbp_ready_low: got %0h expected 0", noc_rx_ready); end
    tests_run++; if (rx_overflow !== 1'b0) begin tests_failed++; $display("FAIL rxbp_overflow: got %0h expected 0", rx_overflow); end
    tests_run++; if ({rx_valid, rx_data} !== {1'b1, 16'h0200}) begin tests_failed++; $display("FAIL rxbp_head: got %0h expected 10200", {rx_valid, rx_data}); end
  endtask

  // Protocol violation into a full buffer: dropped, sticky flag, no count.
  task automatic test_overflow();
    noc_rx_valid = 1'b1; noc_rx_data = 16'h02FF;
    tick();
    noc_rx_valid = 1'b0;
    tests_run++; if (rx_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %0h expected 1", rx_overflow); end
    tests_run++; if (rx_cnt !== 16'd4) begin tests_failed++; $display("FAIL ovf_rx_cnt: got %0d expected 4", rx_cnt); end
    tick();
    tests_run++; if (rx_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %0h expected 1", rx_overflow); end
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if ({rx_valid, rx_data} !== {1'b1, 16'h0200 + 16'(i)}) begin tests_failed++; $display("FAIL drain%0d: got %0h expected %0h", i, {rx_valid, rx_data}, {1'b1, 16'h0200 + 16'(i)}); end
      tick();
    end
    rx_ready = 1'b0;
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got %0h expected 0", rx_valid); end
    tests_run++; if (noc_rx_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_ready: got %0h expected 1", noc_rx_ready); end
    tests_run++; if ({rx_overflow, rx_misroute} !== 2'b10) begin tests_failed++; $display("FAIL drain_sticky: got %0b expected 10", {rx_overflow, rx_misroute}); end
  endtask

  // Flit for tile (2,2) arrives at (1,1): flagged but still delivered.
  task automatic test_misroute();
    noc_rx_valid = 1'b1; noc_rx_data = 16'h03C3; noc_rx_dest_x = 2'd2; noc_rx_dest_y = 2'd2;
    tick();
    noc_rx_valid = 1'b0;
    tests_run++; if (rx_misroute !== 1'b1) begin tests_failed++; $display("FAIL mis_flag: got %0h expected 1", rx_misroute); end
    tests_run++; if ({rx_valid, rx_data} !== {1'b1, 16'h03C3}) begin tests_failed++; $display("FAIL mis_head: got %0h expected 103c3", {rx_valid, rx_data}); end
    tests_run++; if (rx_cnt !== 16'd5) begin tests_failed++; $display("FAIL mis_rx_cnt: got %0d expected 5", rx_cnt); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_pop: got %0h expected 0", rx_valid); end
  endtask

  // Reset with traffic buffered on both paths discards everything.
  task automatic test_midrun_reset();
    noc_tx_ready = 1'b0; rx_ready = 1'b0;
    noc_rx_dest_x = 2'd1; noc_rx_dest_y = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 16'h0400 + 16'(i); tx_dest_x = 2'd1; tx_dest_y = 2'd1;
      noc_rx_valid = (i < 2); noc_rx_data = 16'h0500 + 16'(i);
      tick();
    end
    tx_valid = 1'b0; noc_rx_valid = 1'b0;
    tests_run++; if ({noc_tx_valid, rx_valid} !== 2'b11) begin tests_failed++; $display("FAIL mrst_loaded: got %0b expected 11", {noc_tx_valid, rx_valid}); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tests_run++; if ({noc_tx_valid, noc_tx_data} !== 17'h0) begin tests_failed++; $display("FAIL mrst_noc_tx: got %0h expected 0", {noc_tx_valid, noc_tx_data}); end
    tests_run++; if ({tx_ready, noc_rx_ready} !== 2'b11) begin tests_failed++; $display("FAIL mrst_readies: got %0b expected 11", {tx_ready, noc_rx_ready}); end
    tests_run++; if ({rx_valid, rx_data} !== 17'h0) begin tests_failed++; $display("FAIL mrst_rx: got %0h expected 0", {rx_valid, rx_data}); end
    tests_run++; if ({rx_overflow, rx_misroute} !== 2'b00) begin tests_failed++; $display("FAIL mrst_sticky: got %0b expected 00", {rx_overflow, rx_misroute}); end
    tests_run++; if ({tx_cnt, rx_cnt} !== 32'h0) begin tests_failed++; $display("FAIL mrst_counters: got %0h expected 0", {tx_cnt, rx_cnt}); end
    noc_tx_ready = 1'b1; rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if ({noc_tx_valid, rx_valid} !== 2'b00) begin tests_failed++; $display("FAIL mrst_ghost%0d: got %0b expected 00", i, {noc_tx_valid, rx_valid}); end
    end
    tests_run++; if (tx_cnt !== 16'd0) begin tests_failed++; $display("FAIL mrst_tx_cnt_after: got %0d expected 0", tx_cnt); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b0;
    tx_valid = 1'b0; tx_data = '0; tx_dest_x = '0; tx_dest_y = '0;
    rx_ready = 1'b0; noc_tx_ready = 1'b0;
    noc_rx_valid = 1'b0; noc_rx_data = '0; noc_rx_dest_x = '0; noc_rx_dest_y = '0;
    test_reset();
    test_single_inject();
    test_tx_backpressure();
    test_rx_backpressure();
    test_overflow();
    test_misroute();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
